// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_pkg
//  Description : Shared door-timer definitions. Holds the door sequencer state
//                encoding and the default animation/hold/extension constants
//                used as parameter defaults by door_timer_n.
//  Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    // Door sequencer states. The width is fixed so the encoding is stable
    // across tools and visible in waveforms.
    typedef enum logic [2:0] {
        DS_IDLE    = 3'd0,
        DS_OPENING = 3'd1,
        DS_HOLD    = 3'd2,
        DS_CLOSING = 3'd3,
        DS_DONE    = 3'd4
    } door_state_t;

    localparam int DOOR_STAGES = 4;
    localparam int DOOR_HOLD   = 16;
    localparam int DOOR_EXT    = 20;

endpackage
`default_nettype wire

// File: rtl/edge_detect_rise.sv
`default_nettype none
// ============================================================================
//  Module      : edge_detect_rise
//  Description : 1-bit rising-edge detector. rise_o is high for the CP cycle
//                in which d_i is high and was low on the previous CP edge.
//  Ports       : CP     - clock
//                rst    - synchronous active-high reset (clears history)
//                d_i    - level input, already synchronous to CP
//                rise_o - rising-edge indication
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_detect_rise (
    input  logic CP,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge CP) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= d_i;
        end
    end

    assign rise_o = d_i & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/door_timer_n.sv
`default_nettype none
// ============================================================================
//  Module      : door_timer_n
//  Description : Parametrised door-open sequencer. Steps the door animation
//                open, holds it fully open for a tick-counted time, then
//                steps it closed. Supports obstruction re-open, close-now,
//                a bounded number of delay-close extensions and an end_open
//                completion pulse. All timing advances on the tick strobe.
//  Ports       : CP         - system clock
//                rst        - synchronous active-high reset
//                tick       - one-cycle timing strobe
//                st_open    - level open request from the control FSM
//                delay      - delay-close button (rising edge honoured)
//                close      - close-now button, sampled on tick
//                obstruct   - obstruction sensor, sampled on tick
//                disp_stage - door position, 0 = closed, STAGES-1 = open
//                count      - remaining hold ticks while holding, else 0
//                end_open   - one-cycle pulse when the door has closed
//                busy       - high whenever the sequencer is not idle
//                ext_used   - delay extensions consumed this open cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module door_timer_n
    import elevator_pkg::*;
#(
    parameter int STAGES     = DOOR_STAGES,
    parameter int HOLD_TICKS = DOOR_HOLD,
    parameter int EXT_TICKS  = DOOR_EXT,
    parameter int MAX_EXT    = 3,
    parameter int CW         = 7
) (
    input  logic                      CP,
    input  logic                      rst,
    input  logic                      tick,
    input  logic                      st_open,
    input  logic                      delay,
    input  logic                      close,
    input  logic                      obstruct,
    output logic [$clog2(STAGES)-1:0] disp_stage,
    output logic [CW-1:0]             count,
    output logic                      end_open,
    output logic                      busy,
    output logic [1:0]                ext_used
);

    localparam int SW = $clog2(STAGES);

    localparam logic [SW-1:0] C_TOP    = SW'(STAGES - 1);
    localparam logic [SW-1:0] C_TOP_M1 = SW'(STAGES - 2);
    localparam logic [SW-1:0] C_ONE    = SW'(1);
    localparam logic [CW-1:0] C_HOLD   = CW'(HOLD_TICKS);
    localparam logic [CW-1:0] C_EXT    = CW'(EXT_TICKS);
    localparam logic [CW-1:0] C_CNT1   = CW'(1);
    localparam logic [1:0]    C_MAX    = 2'(MAX_EXT);

    door_state_t state_q;
    logic        ext_pend_q;   // delay honoured while opening, applied at hold entry
    logic        w_delay_rise;
    logic        w_delay_ok;

    edge_detect_rise u_delay_edge (
        .CP     (CP),
        .rst    (rst),
        .d_i    (delay),
        .rise_o (w_delay_rise)
    );

    // A delay press only counts while the door is opening or holding and the
    // per-cycle extension budget is not yet spent.
    assign w_delay_ok = w_delay_rise
                      && ((state_q == DS_OPENING) || (state_q == DS_HOLD))
                      && (ext_used < C_MAX);

    always_ff @(posedge CP) begin
        if (rst) begin
            state_q    <= DS_IDLE;
            disp_stage <= '0;
            count      <= '0;
            end_open   <= 1'b0;
            busy       <= 1'b0;
            ext_used   <= 2'd0;
            ext_pend_q <= 1'b0;
        end else begin
            end_open <= 1'b0;

            if (w_delay_ok) begin
                ext_used <= ext_used + 2'd1;
            end

            case (state_q)
                DS_IDLE: begin
                    if (st_open) begin
                        state_q    <= DS_OPENING;
                        busy       <= 1'b1;
                        ext_pend_q <= 1'b0;
                    end
                end

                DS_OPENING: begin
                    if (w_delay_ok) begin
                        ext_pend_q <= 1'b1;
                    end
                    if (tick) begin
                        if (!st_open) begin
                            // Abort: close from where the door is now. count
                            // is already 0 outside HOLD.
                            state_q <= DS_CLOSING;
                        end else begin
                            disp_stage <= disp_stage + 1'b1;
                            if (disp_stage == C_TOP_M1) begin
                                state_q    <= DS_HOLD;
                                // A press on the entry tick itself also counts.
                                count      <= (ext_pend_q || w_delay_ok) ? C_EXT : C_HOLD;
                                ext_pend_q <= 1'b0;
                            end
                        end
                    end
                end

                DS_HOLD: begin
                    if (tick) begin
                        if (!st_open || close) begin
                            // Close/abort wins over any reload on the same tick;
                            // ext_used has still been stepped above.
                            state_q <= DS_CLOSING;
                            count   <= '0;
                        end else if (w_delay_ok) begin
                            count <= C_EXT;
                        end else if (obstruct) begin
                            count <= C_HOLD;
                        end else if (count <= C_CNT1) begin
                            state_q <= DS_CLOSING;
                            count   <= '0;
                        end else begin
                            count <= count - 1'b1;
                        end
                    end else if (w_delay_ok) begin
                        // Delay reload is the one hold-time change allowed
                        // between ticks.
                        count <= C_EXT;
                    end
                end

                DS_CLOSING: begin
                    if (tick) begin
                        if (obstruct) begin
                            // Reverse direction one stage; reaching the top
                            // restarts a full hold.
                            if (disp_stage >= C_TOP_M1) begin
                                disp_stage <= C_TOP;
                                state_q    <= DS_HOLD;
                                count      <= C_HOLD;
                            end else begin
                                disp_stage <= disp_stage + 1'b1;
                                state_q    <= DS_OPENING;
                            end
                        end else if (disp_stage <= C_ONE) begin
                            disp_stage <= '0;
                            end_open   <= 1'b1;
                            state_q    <= DS_DONE;
                        end else begin
                            disp_stage <= disp_stage - 1'b1;
                        end
                    end
                end

                DS_DONE: begin
                    if (!st_open) begin
                        state_q  <= DS_IDLE;
                        busy     <= 1'b0;
                        ext_used <= 2'd0;
                    end
                end

                default: begin
                    state_q <= DS_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/door_timer_n.md
Name: door_timer_n

Overview:
- Parametrised successor to the fixed-length door-open timer.
- Sequences door animation: opening stages, hold, closing stages.
- Hold time, stage count and extension length are parameters; adds obstruction re-open, close-early, bounded delay extension and a done handshake.
- Sits between the elevator control FSM (issues st_open, consumes end_open) and the display driver (consumes disp_stage); advanced by the 4 Hz tick strobe from the clock divider.

Parameters:
- STAGES, 4: door animation positions 0 (closed) .. STAGES-1 (fully open); must be ≥ 2.
- HOLD_TICKS, 16: ticks held fully open before closing.
- EXT_TICKS, 20: hold ticks reloaded on each delay press.
- MAX_EXT, 3: maximum delay presses honoured per open cycle.
- CW, 7: width of the count output; must hold max(HOLD_TICKS, EXT_TICKS).

Ports:
- CP, in, 1: system clock (32 Hz domain).
- rst, in, 1: synchronous, active-high reset.
- tick, in, 1: one-CP-cycle enable strobe (4 Hz); all timing advances only on tick.
- st_open, in, 1: level open request from the control FSM.
- delay, in, 1: delay-close button, level; rising edge detected internally.
- close, in, 1: close-now button, level; sampled on tick.
- obstruct, in, 1: door obstruction sensor, level.
- disp_stage, out, $clog2(STAGES): current door position for display.
- count, out, CW: remaining hold ticks in HOLD, else 0.
- end_open, out, 1: one-CP-cycle pulse when the door is fully closed after a cycle.
- busy, out, 1: high in any state except IDLE.
- ext_used, out, 2: delay presses consumed in this cycle.

Behaviour:
- Reset: state IDLE; disp_stage = 0, count = 0, end_open = 0, busy = 0, ext_used = 0, edge register = 0.
- States:
  - IDLE: st_open=1 → OPENING on the next CP, busy = 1.
  - OPENING: each tick, disp_stage += 1. At STAGES-1 → HOLD, count = HOLD_TICKS.
  - HOLD: each tick, count -= 1.
    - Leave → CLOSING when count == 1 at a tick (count becomes 0), or when close = 1 at a tick (count cleared to 0).
    - close has priority over count decrement.
  - CLOSING: each tick, disp_stage -= 1.
    - obstruct = 1 at a tick → OPENING; disp_stage += 1 that tick (direction reversal, no skip).
    - Tick with disp_stage == 1 → disp_stage = 0, end_open = 1 for that CP cycle, → DONE.
  - DONE: wait for st_open = 0, then → IDLE. end_open does not repeat.
- Delay: rising edge of delay (CP-synchronous, independent of tick) in OPENING or HOLD with ext_used < MAX_EXT:
  - ext_used += 1; if in HOLD, count = EXT_TICKS.
  - If in OPENING, the extension applies at HOLD entry: count = EXT_TICKS instead of HOLD_TICKS.
  - Edges at ext_used == MAX_EXT, or in other states, are ignored.
- Delay edge and close on the same tick in HOLD: close wins; ext_used still increments.
- obstruct in HOLD: count reloaded to HOLD_TICKS on each tick it is high (no cap). Ignored in OPENING, DONE and IDLE.
- st_open = 0 in OPENING/HOLD/CLOSING: abort → CLOSING from the current disp_stage; count = 0; end_open is still produced at closure.
- ext_used clears on entry to IDLE.
- No output changes on non-tick cycles except: the delay reload, end_open deassert, and busy/state transitions IDLE↔OPENING and DONE→IDLE.
- rst mid-operation: everything returns to reset values on the next CP edge; no end_open is emitted.
- All outputs are registered. Latency: st_open to busy is 1 CP; tick to disp_stage change is 1 CP.

Decomposition:
- Shared package elevator_pkg holds:
  - state encoding constants: DS_IDLE, DS_OPENING, DS_HOLD, DS_CLOSING, DS_DONE;
  - default constants DOOR_STAGES = 4, DOOR_HOLD = 16, DOOR_EXT = 20.
- One natural sub-module: edge_detect_rise (1-bit rising-edge detector on CP with sync reset), used for delay. The rest is a single FSM plus counters.

Test Plan:
- Nominal, defaults, tick every 8 CP, st_open held → disp_stage 0→1→2→3 over 3 ticks; count 16→0 over 16 ticks; disp_stage 3→0 over 3 ticks; end_open is a single pulse on tick 22; DONE until st_open=0, then busy = 0.
- Delay edge at count = 5 in HOLD → count = 20; four more presses → only 2 more honoured (ext_used = 3); the remaining presses leave count unchanged.
- close asserted at count = 10 → next tick count = 0 and CLOSING begins; end_open 3 ticks later.
- obstruct at disp_stage = 2 in CLOSING → disp_stage goes to 3 on that tick, then full HOLD_TICKS hold again; end_open only after the final closure.
- st_open dropped in OPENING at disp_stage = 2 → CLOSING 2→1→0, end_open pulse, then IDLE.
- rst asserted in HOLD with count = 7 → next CP: all outputs 0, IDLE; no end_open. Also run with STAGES = 8, HOLD_TICKS = 40 and check 7-tick open/close ramps.
